uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_DIVISOR_WIDTH, default 24, giving the width of clockDivisor.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx  in  1  asynchronous serial line; idle high.
- dataBits  in  2  data bits = dataBits+5.
- hasParity  in  1  parity bit present.
- parityMode  in  2  00 space, 11 mark, 10 even, 01 odd.
- extraStopBit  in  1  second stop bit present.
- clockDivisor  in  CLOCK_DIVISOR_WIDTH  bit period = clockDivisor+1 clk cycles.
- dataOut  out  8  received word, right-justified, unused upper bits 0.
- rxValid  out  1  dataOut holds an unacknowledged word.
- rxAck  in  1  consumer takes the word.
- parityError, framingError, breakDetect, overrun  out  1 each  status for the current dataOut.

Function
REQ-003 SHALL pass rx through a 2-flop synchronizer; all logic below uses the synchronized value rxs.
REQ-004 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
REQ-005 IDLE: on rxs==0, SHALL latch dataBits, hasParity, parityMode, extraStopBit and clockDivisor, clear bit counter cnt to 0, and enter START; config changes mid-frame SHALL have no effect.
REQ-006 cnt SHALL increment every cycle outside IDLE/WAIT_IDLE and clear to 0 on each sample.
REQ-007 START SHALL sample when cnt == latchedDivisor>>1: rxs==1 -> IDLE (false start, no output change); rxs==0 -> DATA.
REQ-008 DATA/PARITY/STOP1/STOP2 SHALL each sample when cnt == latchedDivisor, i.e. every latchedDivisor+1 cycles.
REQ-009 DATA SHALL shift in dataBits+5 bits LSB first, then go to PARITY if hasParity, else STOP1.
REQ-010 Expected parity SHALL be: even -> XOR of data bits; odd -> its inverse; mark -> 1; space -> 0; a mismatch sets the frame's parity error.
REQ-011 STOP1 SHALL go to STOP2 if extraStopBit, else complete; STOP2 SHALL complete; a stop sample of 0 SHALL set the frame's framing error.
REQ-012 Break SHALL be flagged when all data bits, the parity bit (if present) and STOP1 all sample 0.
REQ-013 On completion, on the edge of the final stop sample, SHALL load dataOut, parityError, framingError and breakDetect, and set rxValid; rxValid is visible in the following cycle.
REQ-014 After completion SHALL enter IDLE if no framing error, else WAIT_IDLE; WAIT_IDLE SHALL leave for IDLE only once rxs==1.
REQ-015 rxValid SHALL stay 1 until a cycle with rxAck==1, then clear together with overrun; rxAck with rxValid==0 SHALL be ignored.
REQ-016 Completion while rxValid==1 and rxAck==0 SHALL overwrite dataOut and flags and set overrun=1.
REQ-017 Completion in the same cycle as rxAck SHALL load the new word, keep rxValid=1, and leave overrun=0.
REQ-018 clockDivisor==0 SHALL give one sample per cycle with the START sample at cnt==0.
REQ-019 cnt SHALL be CLOCK_DIVISOR_WIDTH bits wide; equality compares SHALL be full width with no wrap before a match.

Reset
REQ-020 rst_n==0 at a clock edge SHALL force state IDLE, cnt=0, both synchronizer flops=1, dataOut=0, and rxValid, parityError, framingError, breakDetect, overrun=0.
REQ-021 Reset mid-frame SHALL abort the frame with no rxValid; reception SHALL restart only on a new falling edge after rst_n returns high.

Verification
REQ-022 Divisor 15, 8N1, frame 0xA5 -> dataOut=0xA5, rxValid 1 cycle after the stop sample, all flags 0.
REQ-023 Divisor 15, 7E1, byte 0x35 with parity bit 1 -> dataOut=0x35, parityError=1, framingError=0.
REQ-024 Divisor 15, 3-cycle low glitch on rx -> no state change beyond START, rxValid stays 0.
REQ-025 Divisor 15, 8N2, rx low for 12 bit periods -> dataOut=0x00, breakDetect=1, framingError=1; no new frame until rx high.
REQ-026 Two back-to-back 8N1 frames 0x11, 0x22 with no rxAck -> dataOut=0x22, overrun=1; rxAck -> rxValid=0, overrun=0.
REQ-027 rst_n low during DATA bit 3, then frame 0x5A -> first frame discarded, dataOut=0x5A, no errors.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized rx, per-frame latched configuration,
// mid-bit sampling, parity/framing/break detection and an rxValid/rxAck handshake with overrun.
module uart_receiver #(
  parameter int CLOCK_DIVISOR_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  output logic [7:0]                     dataOut,
  output logic                           rxValid,
  input  logic                           rxAck,
  output logic                           parityError,
  output logic                           framingError,
  output logic                           breakDetect,
  output logic                           overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } state_t;

  state_t state, nextState;

  logic                           rxMeta, rxs;
  logic [CLOCK_DIVISOR_WIDTH-1:0] cnt;
  logic [CLOCK_DIVISOR_WIDTH-1:0] latDiv;
  logic [CLOCK_DIVISOR_WIDTH-1:0] halfDiv;
  logic [1:0]                     latBits;
  logic                           latHasPar;
  logic [1:0]                     latParMode;
  logic                           latExtraStop;
  logic [2:0]                     bitIdx;
  logic [7:0]                     shiftData;
  logic                           parErrAcc, frmErrAcc, brkAcc;
  logic                           sampleTick, complete, expPar;
  logic                           frameFrm, frameBrk;

  assign halfDiv = latDiv >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxs    <= rxMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    case (latParMode)
      2'b10:   expPar = ^shiftData;
      2'b01:   expPar = ~^shiftData;
      2'b11:   expPar = 1'b1;
      default: expPar = 1'b0;
    endcase
  end

  // Stop-bit samples fold the current rxs into the accumulated flags so completion sees them.
  always_comb begin
    nextState  = state;
    sampleTick = 1'b0;
    complete   = 1'b0;
    frameFrm   = frmErrAcc | ~rxs;
    frameBrk   = brkAcc;
    case (state)
      IDLE: if (!rxs) nextState = START;
      START:
        if (cnt == halfDiv) begin
          sampleTick = 1'b1;
          nextState  = rxs ? IDLE : DATA;
        end
      DATA:
        if (cnt == latDiv) begin
          sampleTick = 1'b1;
          if (bitIdx == ({1'b0, latBits} + 3'd4))
            nextState = latHasPar ? PARITY : STOP1;
        end
      PARITY:
        if (cnt == latDiv) begin
          sampleTick = 1'b1;
          nextState  = STOP1;
        end
      STOP1:
        if (cnt == latDiv) begin
          sampleTick = 1'b1;
          frameBrk   = brkAcc & ~rxs;
          if (latExtraStop) begin
            nextState = STOP2;
          end else begin
            complete  = 1'b1;
            nextState = frameFrm ? WAIT_IDLE : IDLE;
          end
        end
      STOP2:
        if (cnt == latDiv) begin
          sampleTick = 1'b1;
          complete   = 1'b1;
          nextState  = frameFrm ? WAIT_IDLE : IDLE;
        end
      WAIT_IDLE: if (rxs) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      latDiv       <= '0;
      latBits      <= 2'b00;
      latHasPar    <= 1'b0;
      latParMode   <= 2'b00;
      latExtraStop <= 1'b0;
      bitIdx       <= 3'd0;
      shiftData    <= 8'h00;
      parErrAcc    <= 1'b0;
      frmErrAcc    <= 1'b0;
      brkAcc       <= 1'b0;
    end else begin
      if (state == IDLE || state == WAIT_IDLE || sampleTick) cnt <= '0;
      else                                                   cnt <= cnt + 1'b1;

      if (state == IDLE && !rxs) begin
        latDiv       <= clockDivisor;
        latBits      <= dataBits;
        latHasPar    <= hasParity;
        latParMode   <= parityMode;
        latExtraStop <= extraStopBit;
        bitIdx       <= 3'd0;
        shiftData    <= 8'h00;
        parErrAcc    <= 1'b0;
        frmErrAcc    <= 1'b0;
        brkAcc       <= 1'b1;
      end

      if (sampleTick) begin
        case (state)
          DATA: begin
            shiftData[bitIdx] <= rxs;
            bitIdx            <= bitIdx + 3'd1;
            brkAcc            <= brkAcc & ~rxs;
          end
          PARITY: begin
            parErrAcc <= rxs ^ expPar;
            brkAcc    <= brkAcc & ~rxs;
          end
          STOP1: begin
            frmErrAcc <= frmErrAcc | ~rxs;
            brkAcc    <= brkAcc & ~rxs;
          end
          STOP2: frmErrAcc <= frmErrAcc | ~rxs;
          default: ;
        endcase
      end
    end
  end

  // A completion always wins over an acknowledge; overrun only when the old word was never taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOut      <= 8'h00;
      rxValid      <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      breakDetect  <= 1'b0;
      overrun      <= 1'b0;
    end else if (complete) begin
      dataOut      <= shiftData;
      parityError  <= parErrAcc;
      framingError <= frameFrm;
      breakDetect  <= frameBrk;
      rxValid      <= 1'b1;
      overrun      <= rxValid & ~rxAck;
    end else if (rxValid && rxAck) begin
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected words are queued when a frame is sent
// and compared against {rxValid, dataOut, parityError, framingError, breakDetect, overrun}.
module tb_uart_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [1:0]  dataBits;
  logic        hasParity;
  logic [1:0]  parityMode;
  logic        extraStopBit;
  logic [23:0] clockDivisor;
  logic [7:0]  dataOut;
  logic        rxValid;
  logic        rxAck;
  logic        parityError, framingError, breakDetect, overrun;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [12:0] sb[$];
  wire  [12:0] status = {rxValid, dataOut, parityError, framingError, breakDetect, overrun};

  always #5 clk = ~clk;

  uart_receiver #(.CLOCK_DIVISOR_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .dataBits(dataBits), .hasParity(hasParity),
    .parityMode(parityMode), .extraStopBit(extraStopBit), .clockDivisor(clockDivisor),
    .dataOut(dataOut), .rxValid(rxValid), .rxAck(rxAck), .parityError(parityError),
    .framingError(framingError), .breakDetect(breakDetect), .overrun(overrun)
  );

  function automatic logic parityModel(input logic [1:0] mode, input logic [7:0] d, input int nData);
    logic x;
    x = 1'b0;
    for (int j = 0; j < nData; j++) x = x ^ d[j];
    case (mode)
      2'b10:   return x;
      2'b01:   return ~x;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Starts on the next rising edge (+1) and holds each bit for clockDivisor+1 cycles.
  task automatic sendFrame(input logic [7:0] d, input int nData, input logic withPar,
                           input logic parBit, input int nStop);
    logic [15:0] seq;
    int n, per;
    per = int'(clockDivisor) + 1;
    seq = '1;
    seq[0] = 1'b0;
    for (int j = 0; j < nData; j++) seq[1+j] = d[j];
    n = 1 + nData;
    if (withPar) begin
      seq[n] = parBit;
      n++;
    end
    n += nStop;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      rx = seq[i];
      repeat (per) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic doAck();
    @(posedge clk); #1 rxAck = 1'b1;
    @(posedge clk); #1 rxAck = 1'b0;
  endtask

  task automatic setConfig(input logic [1:0] db, input logic hp, input logic [1:0] pm,
                           input logic es, input logic [23:0] div);
    dataBits = db; hasParity = hp; parityMode = pm; extraStopBit = es; clockDivisor = div;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nCompared++;
    if (status !== 13'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold: got %h expected %h", status, 13'h0);
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    nCompared++;
    if (status !== 13'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: got %h expected %h", status, 13'h0);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [12:0] exp;
    lat = -1;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    sb.push_back({1'b1, 8'hA5, 4'b0000});
    fork
      sendFrame(8'hA5, 8, 1'b0, 1'b0, 1);
      begin
        @(posedge clk); #1;
        for (int n = 1; n <= 200; n++) begin
          @(posedge clk); #1;
          if (rxValid && lat < 0) lat = n;
        end
      end
    join
    nCompared++;
    if (lat !== 155) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected %0d", lat, 155);
    end
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL basic_word: got %h expected %h", status, exp);
    end
    doAck();
    nCompared++;
    if (rxValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_ack: rxValid got %b expected 0", rxValid);
    end
  endtask

  task automatic test_parity();
    logic [12:0] exp;
    logic [7:0]  d, mask;
    logic        flip, pb;
    int          nD;
    setConfig(2'b10, 1'b1, 2'b10, 1'b0, 24'd15);
    sb.push_back({1'b1, 8'h35, 4'b1000});
    sendFrame(8'h35, 7, 1'b1, 1'b1, 1);
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL parity_7E1: got %h expected %h", status, exp);
    end
    doAck();
    for (int i = 0; i < 8; i++) begin
      setConfig(2'(3 - (i % 4)), 1'b1, 2'(i % 4), 1'b0, 24'd15);
      nD   = 8 - (i % 4);
      mask = 8'((1 << nD) - 1);
      d    = 8'($urandom) & mask;
      flip = (i >= 4);
      pb   = parityModel(2'(i % 4), d, nD) ^ flip;
      sb.push_back({1'b1, d, flip, 3'b000});
      sendFrame(d, nD, 1'b1, pb, 1);
      exp = sb.pop_front();
      nCompared++;
      if (status !== exp) begin
        nMismatched++;
        $display("[TB] FAIL parity_mode%0d_flip%0b: got %h expected %h", i % 4, flip, status, exp);
      end
      doAck();
    end
  endtask

  task automatic test_glitch();
    logic [12:0] exp;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    nCompared++;
    if (rxValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL glitch_novalid: rxValid got %b expected 0", rxValid);
    end
    sb.push_back({1'b1, 8'h3C, 4'b0000});
    sendFrame(8'h3C, 8, 1'b0, 1'b0, 1);
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL glitch_recover: got %h expected %h", status, exp);
    end
    doAck();
  endtask

  task automatic test_break();
    logic [12:0] exp;
    setConfig(2'b11, 1'b0, 2'b00, 1'b1, 24'd15);
    sb.push_back({1'b1, 8'h00, 4'b0110});
    @(posedge clk); #1 rx = 1'b0;
    repeat (192) @(posedge clk);
    #1;
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL break_word: got %h expected %h", status, exp);
    end
    doAck();
    repeat (100) @(posedge clk);
    #1;
    nCompared++;
    if (rxValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL break_wait_idle: rxValid got %b expected 0", rxValid);
    end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    sb.push_back({1'b1, 8'h81, 4'b0000});
    sendFrame(8'h81, 8, 1'b0, 1'b0, 2);
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL break_recover: got %h expected %h", status, exp);
    end
    doAck();
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    sb.push_back({1'b1, 8'h11, 4'b0000});
    sb.push_back({1'b1, 8'h22, 4'b0001});
    sendFrame(8'h11, 8, 1'b0, 1'b0, 1);
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got %h expected %h", status, exp);
    end
    sendFrame(8'h22, 8, 1'b0, 1'b0, 1);
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_overrun: got %h expected %h", status, exp);
    end
    doAck();
    nCompared++;
    if ({rxValid, overrun} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL b2b_ack: {rxValid,overrun} got %b expected 00", {rxValid, overrun});
    end
  endtask

  task automatic test_ack_same_cycle();
    logic [12:0] exp;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    sb.push_back({1'b1, 8'h44, 4'b0000});
    sendFrame(8'h44, 8, 1'b0, 1'b0, 1);
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL ackcoll_first: got %h expected %h", status, exp);
    end
    sb.push_back({1'b1, 8'h99, 4'b0000});
    fork
      sendFrame(8'h99, 8, 1'b0, 1'b0, 1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 rxAck = 1'b1;
        @(posedge clk);
        #1 rxAck = 1'b0;
      end
    join
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL ackcoll_second: got %h expected %h", status, exp);
    end
    doAck();
  endtask

  task automatic test_reset_midframe();
    logic [12:0] exp;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    @(posedge clk); #1 rx = 1'b0;
    repeat (16) @(posedge clk);
    #1 rx = 1'b1;
    repeat (32) @(posedge clk);
    #1 rx = 1'b0;
    repeat (24) @(posedge clk);
    #1 rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    nCompared++;
    if (status !== 13'h0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_abort: got %h expected %h", status, 13'h0);
    end
    sb.push_back({1'b1, 8'h5A, 4'b0000});
    fork
      sendFrame(8'h5A, 8, 1'b0, 1'b0, 1);
      begin
        repeat (40) @(posedge clk);
        #1 setConfig(2'b00, 1'b1, 2'b11, 1'b1, 24'd7);
      end
    join
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL midreset_newframe: got %h expected %h", status, exp);
    end
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    doAck();
  endtask

  task automatic test_div0();
    logic [12:0] exp;
    logic [7:0]  d;
    d = 8'hC3;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd0);
    sb.push_back({1'b1, d, 4'b0000});
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      #1 rx = d[j];
      @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    exp = sb.pop_front();
    nCompared++;
    if (status !== exp) begin
      nMismatched++;
      $display("[TB] FAIL div0_word: got %h expected %h", status, exp);
    end
    doAck();
  endtask

  initial begin
    rx = 1'b1;
    rxAck = 1'b0;
    rst_n = 1'b0;
    setConfig(2'b11, 1'b0, 2'b00, 1'b0, 24'd15);
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_ack_same_cycle();
    test_reset_midframe();
    test_div0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
